dense_25d_ctrl: RTL
===================

# dense_25d_ctrl

Frame sequencer for the `dense_25D` dense/convolution layer. It reads one frame of pixels from a single-port frame memory, presents them to the free-running `dense_25D` shift-register/tree datapath, and marks which `pixel_vector_out` cycles carry valid window results. It sits between the layer's input buffer and the downstream result collector. It provides a start/busy/done handshake to the network-level scheduler.

## Interface
- `P_SR_DEPTH`, 4, pixels per shift-register row of the datapath.
- `NUM_SR_ROWS`, 4, shift-register rows; FILL = P_SR_DEPTH*NUM_SR_ROWS (16).
- `PIPE_LAT`, 7, datapath cycles from last window pixel presented to result on `pixel_vector_out`. This is mult-adder latency 5 plus Z-tree latency (2 for Z_DEPTH=4, 1 for Z_DEPTH=2).
- `FRAME_PIXELS`, 20, pixels per frame. Must be >= FILL; violation is an elaboration-time `$error`.
- `ADDR_W`, 16, width of the memory address and window index.

Ports:
- `clock`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low.
- `start`  in  1  single-cycle frame request; sampled only in IDLE.
- `busy`  out  1  high from the cycle after an accepted start through the `done` cycle inclusive.
- `done`  out  1  one-cycle pulse after the last valid window.
- `rd_en`  out  1  frame-memory read strobe; read data appears 1 cycle later.
- `rd_addr`  out  ADDR_W  frame-memory address.
- `pix_valid`  out  1  high in the cycle the memory read data is on the datapath `pixel_vector_in`.
- `out_valid`  out  1  `pixel_vector_out` holds a valid window result this cycle.
- `out_last`  out  1  qualifies the final window of the frame; only high together with `out_valid`.
- `window_idx`  out  ADDR_W  index of the current valid window, 0-based; holds its last value otherwise.

## Operation
- States: IDLE, STREAM, DRAIN, DONE.
- IDLE: all strobes low. `start`=1 moves to STREAM and clears the pixel counter and `window_idx`.
- STREAM: `rd_en`=1 every cycle. `rd_addr` = pixel count, running 0..FRAME_PIXELS-1. After issuing address FRAME_PIXELS-1, move to DRAIN.
- `pix_valid` is `rd_en` delayed by 1 register.
- Window tag:
  - A tag is raised in a cycle with `pix_valid`=1 when the presented pixel index p >= FILL-1.
  - The tag is delayed PIPE_LAT cycles (shift register or counter) and becomes `out_valid`.
  - Window w = p-(FILL-1).
  - NUM_WIN = FRAME_PIXELS-FILL+1.
- `window_idx` increments after each `out_valid` cycle. The value shown during `out_valid` is w.
- `out_last` = `out_valid` and w = NUM_WIN-1.
- DRAIN: no reads. Stay until the `out_last` cycle, then move to DONE.
- DONE: `done`=1 for one cycle, then IDLE.
- `start` outside IDLE, including during DONE, is ignored with no side effects. Earliest re-accept is the cycle after `done`.
- The datapath is never stalled. Pixels are issued on consecutive cycles with no gaps, and the downstream must accept every `out_valid`.
- Stale datapath contents from a prior frame are never tagged valid, because the tag requires FILL new pixels.
- Counters are ADDR_W bits. FRAME_PIXELS <= 2^ADDR_W, so there is no wrap within a frame.

## Timing
- Reset (asynchronous, any state): state IDLE. All outputs 0: `busy`, `done`, `rd_en`, `rd_addr`, `pix_valid`, `out_valid`, `out_last`, `window_idx`. The tag pipeline is cleared, so no `out_valid` follows a mid-frame reset.
- Let `start` be sampled at edge 0 (cycle 0 = the cycle before edge 0). Then:
  - `rd_en` is high in cycles 1..FRAME_PIXELS.
  - `pix_valid` is high in cycles 2..FRAME_PIXELS+1.
  - The first `out_valid` is in cycle FILL+1+PIPE_LAT.
  - The last `out_valid` is in cycle FRAME_PIXELS+1+PIPE_LAT.
  - `done` is in the following cycle.
- Total frame latency, start to `done`: FRAME_PIXELS+PIPE_LAT+2 cycles.

## Test plan
- Default params: start at cycle 0.
  - `rd_en` high cycles 1–20, with `rd_addr` 0..19.
  - `out_valid` high cycles 24–28, with `window_idx` 0..4.
  - `out_last` in cycle 28; `done` in cycle 29; `busy` high cycles 1–29.
- Integration with `dense_25D` (Z_DEPTH=4, memory holding a 0,1,2… ramp):
  - First two `out_valid` results are tree 1 = 1140, 1292 and tree 2 = 1732, 1964.
- Integration with `dense_25D` (Z_DEPTH=2, PIPE_LAT=6, same ramp):
  - First two results are tree 1 = 420, 476 and tree 2 = 772, 876.
- `start` held high continuously:
  - Second frame's `rd_en` begins in cycle 31 (start re-accepted at edge 30).
  - No start is accepted during busy or done.
- Reset pulsed low at cycle 22, mid-DRAIN:
  - All outputs are 0 immediately.
  - No `out_valid` appears afterwards.
  - The next start produces a clean 5-window frame with `window_idx` starting at 0.
- FRAME_PIXELS=FILL=16:
  - Exactly one `out_valid`, in cycle 24, with `out_last`=1 and `window_idx`=0.
  - `done` in cycle 25.

Source files
------------

// File: rtl/dense_25d_ctrl.sv
// -----------------------------------------------------------------------------
// dense_25d_ctrl
//
// Frame sequencer for the dense_25D dense/convolution layer. It reads one frame
// of pixels from a single-port frame memory and streams them with no gaps into
// the free-running dense_25D shift-register/tree datapath. It also tags the
// pixel_vector_out cycles that carry a valid window result. A start/busy/done
// handshake connects it to the network-level scheduler.
//
// State table:
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   S_IDLE    | waiting for start; all strobes low
//   S_STREAM  | one memory read per cycle, addresses 0..FRAME_PIXELS-1
//   S_DRAIN   | reads finished; waiting for the final window result
//   S_DONE    | one-cycle done pulse, then back to idle
//
// Parameters:
//   P_SR_DEPTH    pixels per datapath shift-register row
//   NUM_SR_ROWS   shift-register rows (FILL = P_SR_DEPTH*NUM_SR_ROWS)
//   PIPE_LAT      cycles from last window pixel presented to its result
//   FRAME_PIXELS  pixels per frame (>= FILL)
//   ADDR_W        width of memory address and window index
//
// Ports:
//   clock       in   rising-edge clock
//   reset       in   asynchronous, active-low reset
//   start       in   single-cycle frame request, sampled only in S_IDLE
//   busy        out  high from the cycle after accepted start through done
//   done        out  one-cycle pulse after the last valid window
//   rd_en       out  frame-memory read strobe (data returns 1 cycle later)
//   rd_addr     out  frame-memory address
//   pix_valid   out  memory read data is on the datapath input this cycle
//   out_valid   out  datapath output holds a valid window result
//   out_last    out  final window of the frame (only with out_valid)
//   window_idx  out  0-based index of the current valid window
// -----------------------------------------------------------------------------
module dense_25d_ctrl #(
    parameter int P_SR_DEPTH   = 4,
    parameter int NUM_SR_ROWS  = 4,
    parameter int PIPE_LAT     = 7,
    parameter int FRAME_PIXELS = 20,
    parameter int ADDR_W       = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              pix_valid,
    output logic              out_valid,
    output logic              out_last,
    output logic [ADDR_W-1:0] window_idx
);

    localparam int FILL = P_SR_DEPTH * NUM_SR_ROWS;

    // Pixel index at which the datapath first holds a complete window, and the
    // index of the last pixel of the frame.
    localparam logic [ADDR_W-1:0] FIRST_WIN_PIX = ADDR_W'(FILL - 1);
    localparam logic [ADDR_W-1:0] LAST_PIX      = ADDR_W'(FRAME_PIXELS - 1);

    generate
        if (FRAME_PIXELS < FILL) begin : g_bad_frame
            $error("dense_25d_ctrl: FRAME_PIXELS must be >= P_SR_DEPTH*NUM_SR_ROWS");
        end
        if (PIPE_LAT < 1) begin : g_bad_lat
            $error("dense_25d_ctrl: PIPE_LAT must be at least 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_DRAIN  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   pix_idx;     // index of the pixel currently on pixel_vector_in
    logic [PIPE_LAT-1:0] tag_sr;      // window-valid tags in flight through the datapath
    logic [PIPE_LAT-1:0] last_sr;     // final-window tags, aligned with tag_sr

    logic win_tag;
    logic last_tag;

    // A window is complete once FILL fresh pixels have entered the datapath.
    // This gating keeps stale pixels from a prior frame from ever being tagged.
    assign win_tag  = pix_valid && (pix_idx >= FIRST_WIN_PIX);
    assign last_tag = pix_valid && (pix_idx == LAST_PIX);

    // Both taps are flop outputs, so they behave as registered outputs.
    assign out_valid = tag_sr[PIPE_LAT-1];
    assign out_last  = last_sr[PIPE_LAT-1];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            rd_en      <= 1'b0;
            rd_addr    <= '0;
            pix_valid  <= 1'b0;
            pix_idx    <= '0;
            tag_sr     <= '0;
            last_sr    <= '0;
            window_idx <= '0;
        end else begin
            // Memory read latency is one cycle.
            pix_valid <= rd_en;
            if (rd_en) begin
                pix_idx <= rd_addr;
            end

            // Tags ride alongside the datapath pipeline.
            for (int i = PIPE_LAT - 1; i > 0; i--) begin
                tag_sr[i]  <= tag_sr[i-1];
                last_sr[i] <= last_sr[i-1];
            end
            tag_sr[0]  <= win_tag;
            last_sr[0] <= last_tag;

            if (out_valid) begin
                window_idx <= window_idx + ADDR_W'(1);
            end

            done <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        state      <= S_STREAM;
                        busy       <= 1'b1;
                        rd_en      <= 1'b1;
                        rd_addr    <= '0;
                        window_idx <= '0;
                    end
                end
                S_STREAM: begin
                    if (rd_addr == LAST_PIX) begin
                        rd_en <= 1'b0;
                        state <= S_DRAIN;
                    end else begin
                        rd_addr <= rd_addr + ADDR_W'(1);
                    end
                end
                S_DRAIN: begin
                    if (out_last) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    rd_en <= 1'b0;
                end
            endcase
        end
    end

endmodule
